// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor: a single full-adder slice walks the operands
// LSB first, producing a WIDTH-bit result, carry-out and signed overflow.
module serial_addsub_n #(
   parameter int WIDTH = 8
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   input  logic             start,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             OVF,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;

   logic             a_bit;
   logic             b_bit;
   logic             sum_bit;
   logic             carry_next;
   logic             last_bit;

   // The one full-adder slice, fed from the bit selected by the counter.
   always_comb begin
      a_bit      = opa[cnt];
      b_bit      = opb[cnt];
      sum_bit    = a_bit ^ b_bit ^ carry;
      carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
      last_bit   = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         S     <= '0;
         Cout  <= 1'b0;
         OVF   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is A + ~B + 1, so the carry seeds the +1.
                  opa   <= A;
                  opb   <= sub ? ~B : B;
                  carry <= sub ? 1'b1 : Cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               S     <= {sum_bit, S[WIDTH-1:1]};
               carry <= carry_next;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  Cout  <= carry_next;
                  OVF   <= carry ^ carry_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_n.sv
// Checks serial_addsub_n at WIDTH 8, 4 and 16 against a plain-arithmetic
// model: directed corner cases, held start, mid-run reset and random operands.
module tb_serial_addsub_n;

   logic        CLOCK_50;
   logic        resetn;
   logic [15:0] a_in [3];
   logic [15:0] b_in [3];
   logic        cin_in [3];
   logic        sub_in [3];
   logic        start_in [3];

   logic [7:0]  s8;
   logic [3:0]  s4;
   logic [15:0] s16;
   logic        cout_w [3];
   logic        ovf_w [3];
   logic        busy_w [3];
   logic        done_w [3];
   logic [15:0] s_out [3];

   int total = 0;
   int bad   = 0;

   localparam int WID [3] = '{8, 4, 16};

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   serial_addsub_n #(.WIDTH(8)) dut8 (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .A(a_in[0][7:0]), .B(b_in[0][7:0]), .Cin(cin_in[0]), .sub(sub_in[0]),
      .start(start_in[0]), .S(s8), .Cout(cout_w[0]), .OVF(ovf_w[0]),
      .busy(busy_w[0]), .done(done_w[0]));

   serial_addsub_n #(.WIDTH(4)) dut4 (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .A(a_in[1][3:0]), .B(b_in[1][3:0]), .Cin(cin_in[1]), .sub(sub_in[1]),
      .start(start_in[1]), .S(s4), .Cout(cout_w[1]), .OVF(ovf_w[1]),
      .busy(busy_w[1]), .done(done_w[1]));

   serial_addsub_n #(.WIDTH(16)) dut16 (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .A(a_in[2]), .B(b_in[2]), .Cin(cin_in[2]), .sub(sub_in[2]),
      .start(start_in[2]), .S(s16), .Cout(cout_w[2]), .OVF(ovf_w[2]),
      .busy(busy_w[2]), .done(done_w[2]));

   always_comb begin
      s_out[0] = {8'h00, s8};
      s_out[1] = {12'h000, s4};
      s_out[2] = s16;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input int w, input longint v);
      longint m;
      m = (longint'(1) << w) - 1;
      if ((v & m) >= (longint'(1) << (w - 1))) return (v & m) - (longint'(1) << w);
      return v & m;
   endfunction

   // Reference: unsigned sum for S/Cout, signed integer range test for OVF.
   function automatic void model(input int w, input longint a, input longint b,
                                 input bit cin, input bit sbt,
                                 output longint s, output bit co, output bit ov);
      longint m, ob, full, res;
      m    = (longint'(1) << w) - 1;
      ob   = sbt ? (~b & m) : (b & m);
      full = (a & m) + ob + (sbt ? 1 : longint'(cin));
      s    = full & m;
      co   = ((full >> w) & 1) != 0;
      res  = sbt ? sx(w, a) - sx(w, b) : sx(w, a) + sx(w, b) + longint'(cin);
      ov   = (res > (longint'(1) << (w - 1)) - 1) || (res < -(longint'(1) << (w - 1)));
   endfunction

   task automatic check_result(input int i, input string tag, input longint a,
                               input longint b, input bit cin, input bit sbt);
      longint es;
      bit     eco, eov;
      model(WID[i], a, b, cin, sbt, es, eco, eov);
      check({tag, ".S"}, longint'(s_out[i]), es);
      check({tag, ".Cout"}, longint'(cout_w[i]), longint'(eco));
      check({tag, ".OVF"}, longint'(ovf_w[i]), longint'(eov));
      $display("op %s w=%0d a=%0h b=%0h cin=%0d sub=%0d -> S=%0h Cout=%0d OVF=%0d",
               tag, WID[i], a, b, cin, sbt, s_out[i], cout_w[i], ovf_w[i]);
   endtask

   // Wait (bounded) for done; returns posedges counted since the start edge.
   task automatic wait_done(input int i, output int cycles);
      bit got;
      cycles = 0;
      got    = 0;
      while (!got && cycles < WID[i] + 6) begin
         @(posedge CLOCK_50);
         cycles++;
         #1;
         if (done_w[i]) got = 1;
      end
   endtask

   task automatic do_op(input int i, input string tag, input longint a,
                        input longint b, input bit cin, input bit sbt);
      int cycles;
      @(negedge CLOCK_50);
      a_in[i] = a[15:0]; b_in[i] = b[15:0]; cin_in[i] = cin; sub_in[i] = sbt;
      start_in[i] = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start_in[i] = 1'b0;
      // Operands must already be captured; disturb the inputs.
      a_in[i] = 16'($urandom); b_in[i] = 16'($urandom);
      cin_in[i] = 1'($urandom); sub_in[i] = 1'($urandom);
      check({tag, ".busy"}, longint'(busy_w[i]), 1);
      wait_done(i, cycles);
      check({tag, ".latency"}, cycles, WID[i]);
      check({tag, ".busy_done"}, longint'(busy_w[i]), 0);
      check_result(i, tag, a, b, cin, sbt);
      @(posedge CLOCK_50);
      #1;
      check({tag, ".done_pulse"}, longint'(done_w[i]), 0);
   endtask

   initial begin
      int cycles;
      int done_cnt;
      longint ra, rb;
      bit rc, rs;

      resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_in[i] = '0; b_in[i] = '0; cin_in[i] = 0; sub_in[i] = 0; start_in[i] = 0;
      end
      #1;
      check("reset.S", longint'(s8), 0);
      check("reset.busy", longint'(busy_w[0]), 0);
      check("reset.done", longint'(done_w[0]), 0);
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      resetn = 1'b1;

      // Directed WIDTH=8 cases.
      do_op(0, "add_0f_01", 64'h0F, 64'h01, 0, 0);
      do_op(0, "add_ff_01_c", 64'hFF, 64'h01, 1, 0);
      do_op(0, "add_7f_01", 64'h7F, 64'h01, 0, 0);
      do_op(0, "sub_05_07", 64'h05, 64'h07, 0, 1);
      do_op(0, "sub_80_01", 64'h80, 64'h01, 1, 1);
      do_op(0, "sub_00_00", 64'h00, 64'h00, 0, 1);

      // start held through RUN while operands change every cycle.
      @(negedge CLOCK_50);
      a_in[0] = 16'h0033; b_in[0] = 16'h0044; cin_in[0] = 1; sub_in[0] = 0;
      start_in[0] = 1'b1;
      @(posedge CLOCK_50);
      cycles = 0;
      done_cnt = 0;
      while (done_cnt == 0 && cycles < 14) begin
         #1;
         a_in[0] = 16'($urandom); b_in[0] = 16'($urandom);
         cin_in[0] = 1'($urandom); sub_in[0] = 1'($urandom);
         @(posedge CLOCK_50);
         cycles++;
         #1;
         if (done_w[0]) done_cnt++;
      end
      check("held.latency", cycles, 8);
      check_result(0, "held", 64'h33, 64'h44, 1, 0);
      a_in[0] = 16'h0021; b_in[0] = 16'h0012; cin_in[0] = 0; sub_in[0] = 0;
      @(posedge CLOCK_50);
      #1;
      check("held.idle_busy", longint'(busy_w[0]), 0);
      check("held.idle_done", longint'(done_w[0]), 0);
      @(posedge CLOCK_50);
      #1;
      check("held.restart_busy", longint'(busy_w[0]), 1);
      start_in[0] = 1'b0;
      wait_done(0, cycles);
      check("held2.latency", cycles, 8);
      check_result(0, "held2", 64'h21, 64'h12, 0, 0);

      // Reset during RUN cycle 3: outputs clear immediately, no done.
      @(negedge CLOCK_50);
      a_in[0] = 16'h00AA; b_in[0] = 16'h0055; cin_in[0] = 0; sub_in[0] = 0;
      start_in[0] = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start_in[0] = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #2;
      resetn = 1'b0;
      #1;
      check("rst.S", longint'(s8), 0);
      check("rst.Cout", longint'(cout_w[0]), 0);
      check("rst.OVF", longint'(ovf_w[0]), 0);
      check("rst.busy", longint'(busy_w[0]), 0);
      check("rst.done", longint'(done_w[0]), 0);
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      resetn = 1'b1;
      done_cnt = 0;
      repeat (12) begin
         @(posedge CLOCK_50);
         #1;
         if (done_w[0]) done_cnt++;
      end
      check("rst.no_done", done_cnt, 0);
      do_op(0, "post_rst", 64'h01, 64'h01, 0, 0);

      // Random operands at all three widths.
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 30; n++) begin
            ra = longint'($urandom_range(65535));
            rb = longint'($urandom_range(65535));
            rc = 1'($urandom);
            rs = 1'($urandom);
            ra = ra & ((longint'(1) << WID[i]) - 1);
            rb = rb & ((longint'(1) << WID[i]) - 1);
            do_op(i, $sformatf("rnd%0d_%0d", WID[i], n), ra, rb, rc, rs);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
